// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID->EX pipeline register: execute-command
// encodings and the default field widths.
package id_ex_pipe_reg_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_CMD_W      = 4;

  // EXE_CMD_NOP must stay at zero: a bubble is an all-zero bundle.
  typedef enum logic [DEFAULT_CMD_W-1:0] {
    EXE_CMD_NOP = 4'd0,
    EXE_CMD_ADD = 4'd1,
    EXE_CMD_SUB = 4'd2,
    EXE_CMD_AND = 4'd3,
    EXE_CMD_OR  = 4'd4,
    EXE_CMD_NOR = 4'd5,
    EXE_CMD_XOR = 4'd6,
    EXE_CMD_SLA = 4'd7,
    EXE_CMD_SLL = 4'd8,
    EXE_CMD_SRA = 4'd9,
    EXE_CMD_SRL = 4'd10
  } exe_cmd_e;

endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// pipe_field_reg: one pipeline field with rst > flush > freeze > load priority.
// Flush loads the same value as reset, which is the bubble value for every field.
module pipe_field_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         freeze,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every field
  // samples its input from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= RST_VAL;
    end else if (!freeze) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid bit, freeze, flush and control gating.
// Optional saturating stall/flush counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int CMD_W      = DEFAULT_CMD_W
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [DATA_W-1:0]     Instruction_in,
  input  logic [DATA_W-1:0]     Val1_in,
  input  logic [DATA_W-1:0]     Val2_in,
  input  logic [DATA_W-1:0]     Reg2_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  input  logic [CMD_W-1:0]      EXE_CMD_in,
  input  logic                  Br_taken_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic                  WB_EN_in,
  output logic                  valid,
  output logic [DATA_W-1:0]     PC,
  output logic [DATA_W-1:0]     Instruction,
  output logic [DATA_W-1:0]     Val1,
  output logic [DATA_W-1:0]     Val2,
  output logic [DATA_W-1:0]     Reg2,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic [CMD_W-1:0]      EXE_CMD,
  output logic                  Br_taken,
  output logic                  MEM_R_EN,
  output logic                  MEM_W_EN,
  output logic                  WB_EN
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  localparam logic [CMD_W-1:0] CMD_NOP = CMD_W'(EXE_CMD_NOP);

  pipe_field_reg #(.W(1)) u_valid (
    .clk, .rst, .flush, .freeze, .d(valid_in), .q(valid));

  pipe_field_reg #(.W(DATA_W)) u_pc (
    .clk, .rst, .flush, .freeze, .d(PC_in), .q(PC));

  pipe_field_reg #(.W(DATA_W)) u_instruction (
    .clk, .rst, .flush, .freeze, .d(Instruction_in), .q(Instruction));

  pipe_field_reg #(.W(DATA_W)) u_val1 (
    .clk, .rst, .flush, .freeze, .d(Val1_in), .q(Val1));

  pipe_field_reg #(.W(DATA_W)) u_val2 (
    .clk, .rst, .flush, .freeze, .d(Val2_in), .q(Val2));

  pipe_field_reg #(.W(DATA_W)) u_reg2 (
    .clk, .rst, .flush, .freeze, .d(Reg2_in), .q(Reg2));

  pipe_field_reg #(.W(REG_ADDR_W)) u_dest (
    .clk, .rst, .flush, .freeze, .d(Dest_in), .q(Dest));

  pipe_field_reg #(.W(CMD_W), .RST_VAL(CMD_NOP)) u_exe_cmd (
    .clk, .rst, .flush, .freeze, .d(EXE_CMD_in), .q(EXE_CMD));

  // Control enables are qualified by valid_in so an empty slot can never
  // write memory, write the register file or redirect fetch.
  pipe_field_reg #(.W(1)) u_br_taken (
    .clk, .rst, .flush, .freeze, .d(Br_taken_in & valid_in), .q(Br_taken));

  pipe_field_reg #(.W(1)) u_mem_r_en (
    .clk, .rst, .flush, .freeze, .d(MEM_R_EN_in & valid_in), .q(MEM_R_EN));

  pipe_field_reg #(.W(1)) u_mem_w_en (
    .clk, .rst, .flush, .freeze, .d(MEM_W_EN_in & valid_in), .q(MEM_W_EN));

  pipe_field_reg #(.W(1)) u_wb_en (
    .clk, .rst, .flush, .freeze, .d(WB_EN_in & valid_in), .q(WB_EN));

`ifdef ID_EX_PERF_CNT_EN
  // A cycle with both flush and freeze counts only as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!flush && freeze && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus a random
// stream, all checked against a bundle-level reference model.
module tb_id_ex_pipe_reg;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int CW      = 4;
  localparam int TB_CNT  = 4;
  localparam int CNT_MAX = (1 << TB_CNT) - 1;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] val1;
    logic [DW-1:0] val2;
    logic [DW-1:0] reg2;
    logic [AW-1:0] dest;
    logic [CW-1:0] cmd;
    logic          br;
    logic          mr;
    logic          mw;
    logic          wb;
  } bundle_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, valid_in;
  logic [DW-1:0] PC_in, Instruction_in, Val1_in, Val2_in, Reg2_in;
  logic [AW-1:0] Dest_in;
  logic [CW-1:0] EXE_CMD_in;
  logic Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic valid;
  logic [DW-1:0] PC, Instruction, Val1, Val2, Reg2;
  logic [AW-1:0] Dest;
  logic [CW-1:0] EXE_CMD;
  logic Br_taken, MEM_R_EN, MEM_W_EN, WB_EN;
`ifdef ID_EX_PERF_CNT_EN
  logic [TB_CNT-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W(DW), .REG_ADDR_W(AW), .CMD_W(CW)
`ifdef ID_EX_PERF_CNT_EN
    , .CNT_W(TB_CNT)
`endif
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .PC_in(PC_in), .Instruction_in(Instruction_in), .Val1_in(Val1_in),
    .Val2_in(Val2_in), .Reg2_in(Reg2_in), .Dest_in(Dest_in),
    .EXE_CMD_in(EXE_CMD_in), .Br_taken_in(Br_taken_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .valid(valid), .PC(PC), .Instruction(Instruction), .Val1(Val1),
    .Val2(Val2), .Reg2(Reg2), .Dest(Dest), .EXE_CMD(EXE_CMD),
    .Br_taken(Br_taken), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .WB_EN(WB_EN)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int      vectors = 0;
  int      errors  = 0;
  bundle_t exp_b;
  int      exp_stall = 0;
  int      exp_flush = 0;

  function automatic bundle_t actual();
    bundle_t a;
    a.valid = valid;  a.pc   = PC;    a.instr = Instruction;
    a.val1  = Val1;   a.val2 = Val2;  a.reg2  = Reg2;
    a.dest  = Dest;   a.cmd  = EXE_CMD;
    a.br    = Br_taken; a.mr = MEM_R_EN; a.mw = MEM_W_EN; a.wb = WB_EN;
    return a;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.valid = 1'($urandom);
    b.pc    = $urandom; b.instr = $urandom;
    b.val1  = $urandom; b.val2  = $urandom; b.reg2 = $urandom;
    b.dest  = AW'($urandom); b.cmd = CW'($urandom);
    b.br = 1'($urandom); b.mr = 1'($urandom);
    b.mw = 1'($urandom); b.wb = 1'($urandom);
    return b;
  endfunction

  // Drive one cycle's inputs, clock it, and advance the reference model.
  task automatic cycle(input logic r, input logic fl, input logic fz, input bundle_t in);
    rst = r; flush = fl; freeze = fz;
    valid_in = in.valid; PC_in = in.pc; Instruction_in = in.instr;
    Val1_in = in.val1; Val2_in = in.val2; Reg2_in = in.reg2;
    Dest_in = in.dest; EXE_CMD_in = in.cmd;
    Br_taken_in = in.br; MEM_R_EN_in = in.mr; MEM_W_EN_in = in.mw; WB_EN_in = in.wb;
    @(posedge clk);
    if (r) begin
      exp_b = '0; exp_stall = 0; exp_flush = 0;
    end else if (fl) begin
      exp_b = '0;
      if (exp_flush < CNT_MAX) exp_flush++;
    end else if (fz) begin
      if (exp_stall < CNT_MAX) exp_stall++;
    end else begin
      exp_b = in;
      exp_b.br = in.br && in.valid;
      exp_b.mr = in.mr && in.valid;
      exp_b.mw = in.mw && in.valid;
      exp_b.wb = in.wb && in.valid;
    end
    #1;
  endtask

  task automatic test_reset();
    bundle_t ones, b;
    ones = '1;
    cycle(1'b1, 1'b0, 1'b0, ones);
    cycle(1'b1, 1'b0, 1'b0, ones);
    vectors++;
    if (actual() !== bundle_t'('0)) begin
      errors++; $display("FAIL reset_all_zero: got %h want 0", actual());
    end
`ifdef ID_EX_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    b = '0; b.pc = 32'h4; b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    vectors++;
    if (PC !== 32'h4 || valid !== 1'b1) begin
      errors++; $display("FAIL first_load: got PC=%h valid=%b want 00000004/1", PC, valid);
    end
  endtask

  task automatic test_invalid_gating();
    bundle_t b;
    b = '0; b.wb = 1'b1; b.mw = 1'b1; b.mr = 1'b1; b.br = 1'b1;
    b.valid = 1'b0; b.dest = 5'd7;
    cycle(1'b0, 1'b0, 1'b0, b);
    vectors++;
    if (Dest !== 5'd7 || WB_EN !== 1'b0 || MEM_W_EN !== 1'b0 || MEM_R_EN !== 1'b0
        || Br_taken !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_gating: got Dest=%0d WB=%b MW=%b MR=%b BR=%b V=%b want 7/0/0/0/0/0",
               Dest, WB_EN, MEM_W_EN, MEM_R_EN, Br_taken, valid);
    end
    b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    vectors++;
    if (WB_EN !== 1'b1 || MEM_W_EN !== 1'b1 || valid !== 1'b1) begin
      errors++; $display("FAIL valid_enables: got WB=%b MW=%b V=%b want 1/1/1", WB_EN, MEM_W_EN, valid);
    end
  endtask

  task automatic test_freeze();
    bundle_t b;
    b = rand_bundle();
    cycle(1'b1, 1'b0, 1'b0, b);
    b.pc = 32'h10; b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    for (int i = 1; i <= 3; i++) begin
      b.pc = 32'h10 + 32'(4 * i);
      cycle(1'b0, 1'b0, 1'b1, b);
      vectors++;
      if (PC !== 32'h10) begin
        errors++; $display("FAIL freeze_hold_%0d: got PC=%h want 00000010", i, PC);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL freeze_stall_cnt: got %0d want 3", stall_cnt);
    end
`endif
    cycle(1'b0, 1'b0, 1'b0, b);
    vectors++;
    if (PC !== 32'h1C) begin
      errors++; $display("FAIL freeze_release: got PC=%h want 0000001c", PC);
    end
  endtask

  task automatic test_flush_over_freeze();
    bundle_t b;
    b = rand_bundle();
    cycle(1'b1, 1'b0, 1'b0, b);
    b.valid = 1'b1; b.mr = 1'b1; b.cmd = 4'd5;
    cycle(1'b0, 1'b0, 1'b0, b);
    vectors++;
    if (MEM_R_EN !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got MEM_R_EN=%b want 1", MEM_R_EN);
    end
    cycle(1'b0, 1'b1, 1'b1, b);
    vectors++;
    if (actual() !== bundle_t'('0) || EXE_CMD !== 4'd0) begin
      errors++; $display("FAIL flush_bubble: got %h want 0", actual());
    end
`ifdef ID_EX_PERF_CNT_EN
    vectors++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL flush_counts: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_saturation();
    bundle_t b, held;
    b = rand_bundle();
    cycle(1'b1, 1'b0, 1'b0, b);
    b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    held = exp_b;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, rand_bundle());
    vectors++;
    if (actual() !== held) begin
      errors++; $display("FAIL long_freeze_hold: got %h want %h", actual(), held);
    end
`ifdef ID_EX_PERF_CNT_EN
    vectors++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL stall_saturate: got %0d want 15", stall_cnt);
    end
    cycle(1'b1, 1'b0, 1'b1, b);
    vectors++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL stall_reset: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_during_freeze();
    bundle_t b;
    b = rand_bundle(); b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    cycle(1'b0, 1'b0, 1'b1, rand_bundle());
    cycle(1'b1, 1'b0, 1'b1, rand_bundle());
    vectors++;
    if (actual() !== bundle_t'('0)) begin
      errors++; $display("FAIL rst_in_freeze: got %h want 0", actual());
    end
    b = rand_bundle(); b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    vectors++;
    if (PC !== b.pc || Val1 !== b.val1 || Dest !== b.dest || valid !== 1'b1
        || WB_EN !== b.wb) begin
      errors++; $display("FAIL load_after_rst: got PC=%h Val1=%h want %h/%h", PC, Val1, b.pc, b.val1);
    end
  endtask

  task automatic test_random();
    logic r, fl, fz;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      fl = ($urandom_range(0, 5) == 0);
      fz = ($urandom_range(0, 3) == 0);
      cycle(r, fl, fz, rand_bundle());
      vectors++;
      if (actual() !== exp_b) begin
        errors++; $display("FAIL random_bundle_%0d: got %h want %h", i, actual(), exp_b);
      end
`ifdef ID_EX_PERF_CNT_EN
      vectors++;
      if (int'(stall_cnt) !== exp_stall || int'(flush_cnt) !== exp_flush) begin
        errors++;
        $display("FAIL random_counters_%0d: got %0d/%0d want %0d/%0d",
                 i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
`endif
    end
  endtask

  initial begin
    exp_b = '0;
    test_reset();
    test_invalid_gating();
    test_freeze();
    test_flush_over_freeze();
    test_saturation();
    test_reset_during_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
